dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: m0 (core load/store unit) and m1 (DMA/debug).

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory between two requesters:
//   m0 (core LSU) and m1 (DMA/debug). One access at a time.
//   Sequence: grant (IDLE) -> access (ACCESS) -> [merge write (RMW_WR)] -> response (RESP).
//
//   Optional feature macro: DMEM_ARB_RMW_EN
//     defined   : partial writes (be != 4'hF) become read-modify-write, adding one cycle.
//     undefined : be is ignored and every write is a full-word write.
//
// Ports
//   clk, rst                        clock (rising edge), async active-low reset
//   mX_req/we/addr/wdata/be         request fields; held by the master until mX_gnt
//   mX_gnt                          one-cycle combinational grant; fields are captured on that edge
//   mX_rvalid/rdata                 one-cycle response; rdata holds its value between responses
//   mem_we/addr/wdata, mem_rdata    memory port (async read, write on clock edge)
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int PRIO_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_be,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_be,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

`ifdef DMEM_ARB_RMW_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, RMW_WR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
`endif

  state_t      state;
  logic        last_grant;  // 1 = m1 was granted last
  logic        mst_q;       // master owning the current access
  logic        rmw_q;       // current access is a partial write needing a merge cycle
  logic [31:0] rd_q;        // word read during ACCESS

  // Arbitration: only meaningful in IDLE; gnt is suppressed during reset.
  logic        any_req, sel, grant;
  logic        we_in, rmw_in;
  logic [31:0] addr_in, wdata_in;

  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req)
      sel = (PRIO_MODE == 1) ? 1'b0 : ~last_grant;
    else
      sel = m1_req;
  end

  assign grant    = rst & (state == IDLE) & any_req;
  assign m0_gnt   = grant & ~sel;
  assign m1_gnt   = grant &  sel;

  assign we_in    = sel ? m1_we    : m0_we;
  assign addr_in  = sel ? m1_addr  : m0_addr;
  assign wdata_in = sel ? m1_wdata : m0_wdata;

  // Bits outside the word index wrap away by design.
  logic unused_addr;
  assign unused_addr = ^{addr_in[31:AW+2], addr_in[1:0]};

`ifdef DMEM_ARB_RMW_EN
  logic [3:0]  be_in, be_q;
  logic [31:0] merged;
  assign be_in  = sel ? m1_be : m0_be;
  assign rmw_in = we_in & (be_in != 4'hF);
  // mem_wdata still holds the latched write data during ACCESS.
  for (genvar b = 0; b < 4; b++) begin : g_merge
    assign merged[8*b +: 8] = be_q[b] ? mem_wdata[8*b +: 8] : mem_rdata[8*b +: 8];
  end
`else
  logic unused_be;
  assign unused_be = ^{m0_be, m1_be};
  assign rmw_in    = 1'b0;
`endif

  // Response fires leaving ACCESS (plain access) or leaving RMW_WR (merged write).
  // For writes the returned word is always the pre-write contents.
  logic        resp_go;
  logic [31:0] resp_data;
  assign resp_go   = (state == ACCESS) ? ~rmw_q : (state != IDLE && state != RESP);
  assign resp_data = (state == ACCESS) ? mem_rdata : rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mst_q      <= 1'b0;
      rmw_q      <= 1'b0;
      rd_q       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
`ifdef DMEM_ARB_RMW_EN
      be_q       <= '0;
`endif
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;

      if (resp_go) begin
        if (mst_q) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= resp_data;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= resp_data;
        end
      end

      case (state)
        IDLE: if (grant) begin
          mst_q      <= sel;
          last_grant <= sel;
          mem_addr   <= addr_in[AW+1:2];
          mem_wdata  <= wdata_in;
          mem_we     <= we_in & ~rmw_in;
          rmw_q      <= rmw_in;
`ifdef DMEM_ARB_RMW_EN
          be_q       <= be_in;
`endif
          state      <= ACCESS;
        end
        ACCESS: begin
          rd_q <= mem_rdata;
`ifdef DMEM_ARB_RMW_EN
          if (rmw_q) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            state     <= RMW_WR;
          end else begin
            state     <= RESP;
          end
`else
          state <= RESP;
`endif
        end
`ifdef DMEM_ARB_RMW_EN
        RMW_WR: state <= RESP;
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Two instances share stimulus:
//   u_rr (round-robin) carries all data checks, u_fp (fixed priority)
//   is checked for arbitration order. Each has its own behavioural memory.
//   Honours DMEM_ARB_RMW_EN for the partial-write expectations.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RMW_EN
  localparam int          RMW_LAT = 3;
  localparam logic        RMW_WE  = 1'b0;
  localparam logic [31:0] EXP3    = 32'h11BB33DD;
  localparam logic [31:0] EXP_BE0 = 32'h11BB33DD;
`else
  localparam int          RMW_LAT = 2;
  localparam logic        RMW_WE  = 1'b1;
  localparam logic [31:0] EXP3    = 32'hAABBCCDD;
  localparam logic [31:0] EXP_BE0 = 32'h55555555;
`endif

  logic clk, rst, mem_clr;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;

  logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic [7:0]  a_mem_addr;
  logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_addr;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  int n_chk = 0, n_pass = 0;

  dmem_arbiter #(.AW(8), .PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.AW(8), .PRIO_MODE(1)) u_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Behavioural memories: async read, write on rising edge.
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem_a[i] <= '0;
    else if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
  end
  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 256; i++) mem_b[i] <= '0;
    else if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
  end
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one access on u_rr; starts and ends at posedge+1 of an IDLE cycle.
  // Returns response data, grant-to-rvalid latency and the memory port seen in N+1.
  task automatic do_req(input bit m, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int lat,
                        output logic [31:0] ma, output logic mwe);
    int  cyc;
    bit  got;
    rd = '0; lat = -1; ma = '0; mwe = 1'b0;
    if (m) begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_be = be; end
    else   begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_be = be; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (m ? a_m1_gnt : a_m0_gnt) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      m0_req = 0; m1_req = 0;
      return;
    end
    @(posedge clk); #1;
    if (m) m1_req = 0; else m0_req = 0;
    #1;
    ma  = 32'(a_mem_addr);
    mwe = a_mem_we;
    cyc = 1; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (m ? a_m1_rvalid : a_m0_rvalid) begin
        got = 1; lat = cyc; rd = m ? a_m1_rdata : a_m0_rdata;
      end else begin
        @(posedge clk); #2; cyc++;
      end
    end
    if (!got) chk("rvalid_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, ma;
    logic        mwe, seen;
    int          lat;

    rst = 0; mem_clr = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 4'hF;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we",   32'(a_mem_we),    0);
    chk("rst_mem_addr", 32'(a_mem_addr),  0);
    chk("rst_mem_wd",   a_mem_wdata,      0);
    chk("rst_rvalid",   32'({a_m0_rvalid, a_m1_rvalid}), 0);
    chk("rst_rdata0",   a_m0_rdata,       0);
    chk("rst_rdata1",   a_m1_rdata,       0);
    mem_clr = 0; rst = 1;

    // Both masters request continuously for four rounds.
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    m1_req = 1; m1_we = 0; m1_addr = 32'h24;
    for (int r = 0; r < 4; r++) begin
      #1;
      chk($sformatf("rr_m0_r%0d", r), 32'(a_m0_gnt), (r % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_m1_r%0d", r), 32'(a_m1_gnt), (r % 2 == 1) ? 1 : 0);
      chk($sformatf("fp_m0_r%0d", r), 32'({b_m1_gnt, b_m0_gnt}), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      if (r == 3) begin m0_req = 0; m1_req = 0; end
    end
    repeat (3) @(posedge clk);
    #1;

    // Full-word write then read-back.
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, ma, mwe);
    chk("wr_lat",   lat, 2);
    chk("wr_addr",  ma,  4);
    chk("wr_we",    32'(mwe), 1);
    chk("wr_old",   rd,  0);
    do_req(0, 0, 32'h10, 32'h0, 4'hF, rd, lat, ma, mwe);
    chk("rd_lat",   lat, 2);
    chk("rd_we",    32'(mwe), 0);
    chk("rd_data",  rd,  32'hDEADBEEF);

    // Partial write.
    do_req(1, 1, 32'h30, 32'h11223344, 4'hF, rd, lat, ma, mwe);
    do_req(0, 1, 32'h30, 32'hAABBCCDD, 4'b0101, rd, lat, ma, mwe);
    chk("pw_lat",   lat, RMW_LAT);
    chk("pw_we",    32'(mwe), 32'(RMW_WE));
    chk("pw_old",   rd,  32'h11223344);
    do_req(1, 0, 32'h30, 32'h0, 4'hF, rd, lat, ma, mwe);
    chk("pw_mem",   rd,  EXP3);
    do_req(0, 1, 32'h30, 32'h55555555, 4'h0, rd, lat, ma, mwe);
    do_req(1, 0, 32'h30, 32'h0, 4'hF, rd, lat, ma, mwe);
    chk("be0_mem",  rd,  EXP_BE0);

    // Address wrap and byte-offset bits.
    do_req(1, 1, 32'h0000_0400, 32'hCAFEF00D, 4'hF, rd, lat, ma, mwe);
    chk("wrap_addr", ma, 0);
    do_req(0, 0, 32'h0, 32'h0, 4'hF, rd, lat, ma, mwe);
    chk("wrap_rd",   rd, 32'hCAFEF00D);
    do_req(1, 0, 32'h13, 32'h0, 4'hF, rd, lat, ma, mwe);
    chk("off_rd",    rd, 32'hDEADBEEF);
    chk("off_addr",  ma, 4);

    // m1 pulses req only during m0's RESP cycle.
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    #1 chk("drop_m0_gnt", 32'(a_m0_gnt), 1);
    @(posedge clk); #1; m0_req = 0;
    @(posedge clk); #1; m1_req = 1; m1_we = 0; m1_addr = 32'h10;
    #1;
    chk("drop_m0_rv",   32'(a_m0_rvalid), 1);
    chk("drop_m0_rd",   a_m0_rdata, 32'hDEADBEEF);
    chk("drop_m1_resp", 32'(a_m1_gnt), 0);
    @(posedge clk); #1; m1_req = 0;
    seen = 0;
    repeat (6) begin
      #1 seen = seen | a_m1_gnt | a_m1_rvalid;
      @(posedge clk); #1;
    end
    chk("drop_never", 32'(seen), 0);

    // Reset asserted while a write is in ACCESS.
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_be = 4'hF;
    #1 chk("rst_gnt_m1", 32'(a_m1_gnt), 1);
    @(posedge clk); #1; m1_req = 0;
    #1 chk("rst_pre_we", 32'(a_mem_we), 1);
    #1 rst = 0;
    #1;
    chk("rst_mid_we",   32'(a_mem_we), 0);
    chk("rst_mid_addr", 32'(a_mem_addr), 0);
    chk("rst_mid_wd",   a_mem_wdata, 0);
    m0_req = 1; m0_we = 0; m0_addr = 32'h44;
    m1_req = 1; m1_we = 0; m1_addr = 32'h44;
    #1 chk("rst_mid_gnt", 32'({a_m1_gnt, a_m0_gnt}), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #2;
      seen = seen | a_m1_rvalid | a_m0_rvalid;
    end
    chk("rst_no_rv", 32'(seen), 0);
    @(posedge clk); #1; rst = 1;
    #1;
    chk("rst_first_m0", 32'(a_m0_gnt), 1);
    chk("rst_first_m1", 32'(a_m1_gnt), 0);
    @(posedge clk); #1; m0_req = 0; m1_req = 0;
    repeat (3) @(posedge clk);
    #1;
    do_req(0, 0, 32'h40, 32'h0, 4'hF, rd, lat, ma, mwe);
    chk("rst_no_write", rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
